// File: rtl/mmul_parallel_mac_engine.sv
// ---------------------------------------------------------------------------
// mmul_parallel_mac_engine
// Parametrised N_CH-lane dot-product engine. Operand streams in1/in2 (N_CH
// lanes each) are joined in lock-step, multiplied lane-wise (stage 1),
// reduced through an adder tree and accumulated over LEN beats (stage 2).
// One result is emitted per LEN beats and N_OUT results per job.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   clear_i              synchronous soft clear (highest priority)
//   start_i              job start pulse (taken only in IDLE)
//   len_i, n_out_i       beats per output / outputs per job (latched on start)
//   in1_*, in2_*         N_CH-lane operand streams, lane k at [k*DW +: DW]
//   out_data_o/valid/ready  result stream
//   done_o               one-cycle pulse while the FSM is in DONE
//   idle_o               FSM is in IDLE
//   ready_o              FSM is in IDLE or DONE
//   cnt_out_o            output handshakes in the current job
// ---------------------------------------------------------------------------
module mmul_parallel_mac_engine #(
  parameter int unsigned N_CH   = 16,
  parameter int unsigned DW     = 32,
  parameter int unsigned OUT_W  = 32,
  parameter int unsigned LEN_W  = 16,
  parameter bit          SIGNED = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [LEN_W-1:0]     len_i,
  input  logic [LEN_W-1:0]     n_out_i,
  input  logic [N_CH*DW-1:0]   in1_data_i,
  input  logic [N_CH-1:0]      in1_valid_i,
  output logic [N_CH-1:0]      in1_ready_o,
  input  logic [N_CH*DW-1:0]   in2_data_i,
  input  logic [N_CH-1:0]      in2_valid_i,
  output logic [N_CH-1:0]      in2_ready_o,
  output logic [OUT_W-1:0]     out_data_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic                 done_o,
  output logic                 idle_o,
  output logic                 ready_o,
  output logic [LEN_W:0]       cnt_out_o
);

  localparam int unsigned ACC_W = 2 * DW + $clog2(N_CH) + LEN_W;
  localparam logic [LEN_W-1:0] L_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W:0]   C_ONE = {{LEN_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [LEN_W-1:0]     r_len;
  logic [LEN_W-1:0]     r_n_out;
  logic [LEN_W-1:0]     r_beat;
  logic [LEN_W:0]       r_res_cnt;
  logic [LEN_W:0]       r_cnt_out;
  logic                 r_s1_valid;
  logic                 r_s1_last;
  logic [2*DW-1:0]      r_prod [N_CH];
  logic [ACC_W-1:0]     r_acc;
  logic                 r_out_valid;
  logic [OUT_W-1:0]     r_out_data;
  logic                 r_done;
  logic                 r_idle;
  logic                 r_ready;

  logic                 w_start_acc;
  logic                 w_zero;
  logic                 w_all_valid;
  logic                 w_fin;
  logic                 w_stall;
  logic                 w_fire;
  logic                 w_last_beat;
  logic                 w_hs;
  logic [LEN_W:0]       w_cnt_out_inc;
  logic                 w_job_end;
  logic [2*DW-1:0]      w_prod     [N_CH];
  logic [ACC_W-1:0]     w_prod_ext [N_CH];
  logic [ACC_W-1:0]     w_tree_sum;
  logic [ACC_W-1:0]     w_acc_nxt;

  assign w_start_acc   = (r_state == S_IDLE) & start_i;
  assign w_zero        = (r_len == {LEN_W{1'b0}}) | (r_n_out == {LEN_W{1'b0}});
  assign w_all_valid   = (&in1_valid_i) & (&in2_valid_i);
  // All n_out results of the job have already entered the pipeline.
  assign w_fin         = (r_res_cnt == {1'b0, r_n_out});
  // Only a tagged result in stage 1 needs the output register; untagged
  // beats can still be folded into the accumulator while the output waits.
  assign w_stall       = r_out_valid & ~out_ready_i & r_s1_valid & r_s1_last;
  assign w_fire        = (r_state == S_RUN) & w_all_valid & ~w_stall & ~w_zero & ~w_fin;
  assign w_last_beat   = (r_beat == (r_len - L_ONE));
  assign w_hs          = r_out_valid & out_ready_i;
  assign w_cnt_out_inc = r_cnt_out + C_ONE;
  assign w_job_end     = w_hs & (w_cnt_out_inc == {1'b0, r_n_out});

  assign in1_ready_o = {N_CH{w_fire}};
  assign in2_ready_o = {N_CH{w_fire}};

  // Operands are extended to 2*DW (sign or zero) so the truncated product is
  // the correct two's-complement or unsigned result in both modes.
  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    logic [2*DW-1:0] w_a;
    logic [2*DW-1:0] w_b;
    assign w_a = {{DW{SIGNED & in1_data_i[k*DW+DW-1]}}, in1_data_i[k*DW +: DW]};
    assign w_b = {{DW{SIGNED & in2_data_i[k*DW+DW-1]}}, in2_data_i[k*DW +: DW]};
    assign w_prod[k]     = w_a * w_b;
    assign w_prod_ext[k] = {{(ACC_W-2*DW){SIGNED & r_prod[k][2*DW-1]}}, r_prod[k]};
  end

  // Adder tree over the registered lane products.
  always_comb begin
    w_tree_sum = {ACC_W{1'b0}};
    for (int k = 0; k < N_CH; k++) begin
      w_tree_sum = w_tree_sum + w_prod_ext[k];
    end
  end

  assign w_acc_nxt = r_acc + w_tree_sum;

  // FSM next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_zero || w_job_end) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else if (clear_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered status outputs, decoded from the next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_done  <= 1'b0;
      r_idle  <= 1'b1;
      r_ready <= 1'b0;
    end else if (clear_i) begin
      r_done  <= 1'b0;
      r_idle  <= 1'b1;
      r_ready <= 1'b0;
    end else begin
      r_done  <= (w_state_nxt == S_DONE);
      r_idle  <= (w_state_nxt == S_IDLE);
      r_ready <= (w_state_nxt == S_IDLE) | (w_state_nxt == S_DONE);
    end
  end

  // Job configuration latched on an accepted start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_len   <= {LEN_W{1'b0}};
      r_n_out <= {LEN_W{1'b0}};
    end else if (clear_i) begin
      r_len   <= {LEN_W{1'b0}};
      r_n_out <= {LEN_W{1'b0}};
    end else if (w_start_acc) begin
      r_len   <= len_i;
      r_n_out <= n_out_i;
    end else begin
      r_len   <= r_len;
      r_n_out <= r_n_out;
    end
  end

  // Beat counter within one output and count of results issued this job.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_beat    <= {LEN_W{1'b0}};
      r_res_cnt <= {(LEN_W+1){1'b0}};
    end else if (clear_i || w_start_acc) begin
      r_beat    <= {LEN_W{1'b0}};
      r_res_cnt <= {(LEN_W+1){1'b0}};
    end else if (w_fire) begin
      if (w_last_beat) begin
        r_beat    <= {LEN_W{1'b0}};
        r_res_cnt <= r_res_cnt + C_ONE;
      end else begin
        r_beat    <= r_beat + L_ONE;
        r_res_cnt <= r_res_cnt;
      end
    end else begin
      r_beat    <= r_beat;
      r_res_cnt <= r_res_cnt;
    end
  end

  // Stage 1 control: beat valid and last-beat tag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
    end else if (clear_i) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
    end else if (!w_stall) begin
      r_s1_valid <= w_fire;
      r_s1_last  <= w_fire & w_last_beat;
    end else begin
      r_s1_valid <= r_s1_valid;
      r_s1_last  <= r_s1_last;
    end
  end

  // Stage 1 data: lane products, captured on every fire.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < N_CH; k++) r_prod[k] <= {(2*DW){1'b0}};
    end else if (clear_i) begin
      for (int k = 0; k < N_CH; k++) r_prod[k] <= {(2*DW){1'b0}};
    end else if (w_fire) begin
      for (int k = 0; k < N_CH; k++) r_prod[k] <= w_prod[k];
    end else begin
      for (int k = 0; k < N_CH; k++) r_prod[k] <= r_prod[k];
    end
  end

  // Stage 2: accumulate; a tagged beat restarts the accumulator from zero
  // so the next beat starts a fresh sum without a bubble.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_acc <= {ACC_W{1'b0}};
    end else if (clear_i) begin
      r_acc <= {ACC_W{1'b0}};
    end else if (!w_stall && r_s1_valid) begin
      if (r_s1_last) begin
        r_acc <= {ACC_W{1'b0}};
      end else begin
        r_acc <= w_acc_nxt;
      end
    end else begin
      r_acc <= r_acc;
    end
  end

  // Output register: loaded with the completed sum, held until handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_out_valid <= 1'b0;
      r_out_data  <= {OUT_W{1'b0}};
    end else if (clear_i) begin
      r_out_valid <= 1'b0;
      r_out_data  <= {OUT_W{1'b0}};
    end else if (!w_stall && r_s1_valid && r_s1_last) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_acc_nxt[OUT_W-1:0];
    end else if (out_ready_i) begin
      r_out_valid <= 1'b0;
      r_out_data  <= r_out_data;
    end else begin
      r_out_valid <= r_out_valid;
      r_out_data  <= r_out_data;
    end
  end

  // Output handshake counter, cleared when a job is accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt_out <= {(LEN_W+1){1'b0}};
    end else if (clear_i || w_start_acc) begin
      r_cnt_out <= {(LEN_W+1){1'b0}};
    end else if (w_hs) begin
      r_cnt_out <= w_cnt_out_inc;
    end else begin
      r_cnt_out <= r_cnt_out;
    end
  end

  assign out_data_o  = r_out_data;
  assign out_valid_o = r_out_valid;
  assign done_o      = r_done;
  assign idle_o      = r_idle;
  assign ready_o     = r_ready;
  assign cnt_out_o   = r_cnt_out;

endmodule

// File: tb/tb_mmul_parallel_mac_engine.sv
// ---------------------------------------------------------------------------
// Testbench for mmul_parallel_mac_engine. Instance A: 4 lanes x 8 bit,
// instance B: 16 lanes x 8 bit, both signed. Table of single-output jobs
// plus hand-written sequences for skew, backpressure, len=0 and clear.
// ---------------------------------------------------------------------------
module tb_mmul_parallel_mac_engine;

  localparam int NA = 4;
  localparam int NB = 16;
  localparam int DW = 8;
  localparam int LW = 16;
  localparam int OW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             a_clear, a_start, a_ordy, a_ov, a_done, a_idle, a_rdy;
  logic [LW-1:0]    a_len, a_nout;
  logic [NA*DW-1:0] a_in1, a_in2;
  logic [NA-1:0]    a_v1, a_v2, a_r1, a_r2;
  logic [OW-1:0]    a_out;
  logic [LW:0]      a_cnt;

  logic             b_clear, b_start, b_ordy, b_ov, b_done, b_idle, b_rdy;
  logic [LW-1:0]    b_len, b_nout;
  logic [NB*DW-1:0] b_in1, b_in2;
  logic [NB-1:0]    b_v1, b_v2, b_r1, b_r2;
  logic [OW-1:0]    b_out;
  logic [LW:0]      b_cnt;

  mmul_parallel_mac_engine #(.N_CH(NA), .DW(DW), .OUT_W(OW), .LEN_W(LW), .SIGNED(1'b1)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(a_clear), .start_i(a_start),
    .len_i(a_len), .n_out_i(a_nout),
    .in1_data_i(a_in1), .in1_valid_i(a_v1), .in1_ready_o(a_r1),
    .in2_data_i(a_in2), .in2_valid_i(a_v2), .in2_ready_o(a_r2),
    .out_data_o(a_out), .out_valid_o(a_ov), .out_ready_i(a_ordy),
    .done_o(a_done), .idle_o(a_idle), .ready_o(a_rdy), .cnt_out_o(a_cnt));

  mmul_parallel_mac_engine #(.N_CH(NB), .DW(DW), .OUT_W(OW), .LEN_W(LW), .SIGNED(1'b1)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(b_clear), .start_i(b_start),
    .len_i(b_len), .n_out_i(b_nout),
    .in1_data_i(b_in1), .in1_valid_i(b_v1), .in1_ready_o(b_r1),
    .in2_data_i(b_in2), .in2_valid_i(b_v2), .in2_ready_o(b_r2),
    .out_data_o(b_out), .out_valid_o(b_ov), .out_ready_i(b_ordy),
    .done_o(b_done), .idle_o(b_idle), .ready_o(b_rdy), .cnt_out_o(b_cnt));

  typedef struct packed {
    logic [15:0]      len;
    logic [1:0][31:0] in1;
    logic [1:0][31:0] in2;
    logic [31:0]      exp;
  } vec_t;

  vec_t vecs [6];
  int   n_vec = 0;
  int   n_err = 0;
  int   fires;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_to(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  task automatic a_start_job(input logic [15:0] len, input logic [15:0] nout);
    @(negedge clk);
    a_len = len; a_nout = nout; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
  endtask

  // Present one beat on all lanes and return at the negedge after it fired.
  task automatic a_feed(input logic [31:0] d1, input logic [31:0] d2, input string name);
    int n;
    a_in1 = d1; a_in2 = d2; a_v1 = 4'hF; a_v2 = 4'hF;
    #1;
    n = 0;
    while ((a_r1 !== 4'hF || a_r2 !== 4'hF) && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 50) fail_to({name, ".feed"});
    @(negedge clk);
  endtask

  // Called at the negedge after the last-beat fire of a 1-output job.
  task automatic a_finish_single(input logic [31:0] exp, input string name);
    a_v1 = 4'h0; a_v2 = 4'h0;
    check({name, ".valid_early"}, a_ov, 1'b0);
    @(negedge clk);
    check({name, ".valid"}, a_ov, 1'b1);
    check({name, ".data"}, a_out, exp);
    @(negedge clk);
    check({name, ".done"}, a_done, 1'b1);
    check({name, ".cnt"}, a_cnt, 17'd1);
    check({name, ".valid_after"}, a_ov, 1'b0);
    @(negedge clk);
    check({name, ".idle"}, {a_done, a_idle}, 2'b01);
  endtask

  task automatic apply_vec(input vec_t v, input string name);
    a_ordy = 1'b1;
    a_start_job(v.len, 16'd1);
    for (int b = 0; b < int'(v.len); b++) a_feed(v.in1[b], v.in2[b], name);
    a_finish_single(v.exp, name);
  endtask

  task automatic backpressure();
    logic [7:0]  bp_b   [4];
    logic [31:0] bp_exp [4];
    for (int k = 0; k < 4; k++) begin
      bp_b[k]   = 8'(k + 1);
      bp_exp[k] = 32'(10 * (k + 1));
    end
    fires  = 0;
    a_ordy = 1'b0;
    a_start_job(16'd1, 16'd4);
    fork
      begin
        int k = 0;
        int g = 0;
        while (k < 4 && g < 200) begin
          a_in1 = 32'h04030201; a_in2 = {4{bp_b[k]}}; a_v1 = 4'hF; a_v2 = 4'hF;
          #1;
          if (a_r1 == 4'hF) begin
            k++; fires++;
          end
          @(negedge clk);
          g++;
        end
        a_v1 = 4'h0; a_v2 = 4'h0;
        if (k < 4) fail_to("bp.driver");
      end
      begin
        int n = 0;
        int r = 0;
        while (a_ov !== 1'b1 && n < 50) begin
          @(negedge clk); n++;
        end
        if (n >= 50) fail_to("bp.first_valid");
        for (int i = 0; i < 10; i++) begin
          check("bp.hold", {a_ov, a_out}, {1'b1, 32'd10});
          @(negedge clk);
        end
        check("bp.stall_fires", 32'(fires), 32'd2);
        a_ordy = 1'b1;
        n = 0;
        while (r < 4 && n < 100) begin
          if (a_ov === 1'b1) begin
            check("bp.result", a_out, bp_exp[r]);
            r++;
          end
          @(negedge clk);
          n++;
        end
        if (r < 4) fail_to("bp.results");
        check("bp.done", a_done, 1'b1);
        check("bp.cnt", a_cnt, 17'd4);
      end
    join
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{len: 16'd2, in1: {32'h04030201, 32'h04030201}, in2: {32'h01010101, 32'h01010101}, exp: 32'd20};
    vecs[1] = '{len: 16'd1, in1: {32'h0, 32'h04030201}, in2: {32'h0, 32'h04030201}, exp: 32'd30};
    vecs[2] = '{len: 16'd1, in1: {32'h0, 32'hFFFFFFFF}, in2: {32'h0, 32'h02020202}, exp: 32'hFFFFFFF8};
    vecs[3] = '{len: 16'd2, in1: {32'h80808080, 32'h80808080}, in2: {32'h80808080, 32'h80808080}, exp: 32'h00020000};
    vecs[4] = '{len: 16'd2, in1: {32'h01010101, 32'h7F7F7F7F}, in2: {32'h05050505, 32'h80808080}, exp: 32'hFFFF0214};
    vecs[5] = '{len: 16'd1, in1: {32'h0, 32'h0AFE0103}, in2: {32'h0, 32'h02030405}, exp: 32'd33};

    rst_n = 1'b0;
    a_clear = 1'b0; a_start = 1'b0; a_len = 16'd0; a_nout = 16'd0; a_ordy = 1'b1;
    a_in1 = 32'h0; a_in2 = 32'h0; a_v1 = 4'h0; a_v2 = 4'h0;
    b_clear = 1'b0; b_start = 1'b0; b_len = 16'd0; b_nout = 16'd0; b_ordy = 1'b1;
    b_in1 = '0; b_in2 = '0; b_v1 = '0; b_v2 = '0;

    // Reset state and ready_o one cycle after release
    repeat (3) @(negedge clk);
    check("rst.status", {a_idle, a_rdy, a_done, a_ov}, 4'b1000);
    check("rst.cnt", a_cnt, 17'd0);
    check("rst.in_ready", {a_r1, a_r2}, 8'h00);
    rst_n = 1'b1;
    #1;
    check("rst.ready_release", a_rdy, 1'b0);
    @(negedge clk);
    check("rst.ready_1cyc", a_rdy, 1'b1);

    // Table-driven single-output jobs
    for (int i = 0; i < 6; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Lane skew: in1_valid[3] late by 5 cycles
    a_ordy = 1'b1;
    a_start_job(16'd1, 16'd1);
    a_in1 = 32'h04030201; a_in2 = 32'h01010101; a_v1 = 4'b0111; a_v2 = 4'hF;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("skew.no_ready", {a_r1, a_r2}, 8'h00);
      @(negedge clk);
    end
    a_v1 = 4'hF;
    #1;
    check("skew.ready", {a_r1, a_r2}, 8'hFF);
    @(negedge clk);
    a_finish_single(32'd10, "skew");

    // Backpressure, len=1 n_out=4
    backpressure();

    // Signed 16 lanes: -3 * 5 * 16 = -240
    @(negedge clk);
    b_len = 16'd1; b_nout = 16'd1; b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    b_in1 = {NB{8'hFD}}; b_in2 = {NB{8'h05}}; b_v1 = '1; b_v2 = '1;
    #1;
    check("sgn.ready", {b_r1, b_r2}, {(2*NB){1'b1}});
    @(negedge clk);
    b_v1 = '0; b_v2 = '0;
    @(negedge clk);
    check("sgn.valid", b_ov, 1'b1);
    check("sgn.data", b_out, 32'hFFFFFF10);
    @(negedge clk);
    check("sgn.done", b_done, 1'b1);

    // len=0: done 2 cycles after start, nothing consumed, no output
    a_in1 = 32'h04030201; a_in2 = 32'h01010101; a_v1 = 4'hF; a_v2 = 4'hF;
    a_start_job(16'd0, 16'd3);
    check("len0.c1", {a_done, a_ov, a_r1, a_r2}, 10'b0);
    @(negedge clk);
    check("len0.c2_done", {a_done, a_ov, a_r1, a_r2}, {2'b10, 8'h00});
    @(negedge clk);
    check("len0.c3", {a_done, a_idle, a_ov, a_r1, a_r2}, {3'b010, 8'h00});
    check("len0.cnt", a_cnt, 17'd0);
    a_v1 = 4'h0; a_v2 = 4'h0;

    // Clear mid-job while out_valid is pending, with a simultaneous start
    a_ordy = 1'b0;
    a_start_job(16'd1, 16'd2);
    a_feed(32'h04030201, 32'h01010101, "clr");
    a_v1 = 4'h0; a_v2 = 4'h0;
    begin
      int n = 0;
      while (a_ov !== 1'b1 && n < 20) begin
        @(negedge clk); n++;
      end
      if (n >= 20) fail_to("clr.valid");
    end
    check("clr.pre_valid", a_ov, 1'b1);
    a_clear = 1'b1; a_start = 1'b1; a_len = 16'd1; a_nout = 16'd1;
    @(negedge clk);
    a_clear = 1'b0; a_start = 1'b0;
    check("clr.post", {a_idle, a_ov, a_rdy}, 3'b100);
    check("clr.cnt", a_cnt, 17'd0);
    @(negedge clk);
    check("clr.start_ignored", {a_idle, a_rdy, a_ov}, 3'b110);
    apply_vec(vecs[1], "post_clr");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
